// File: rtl/video_stream_pkg.sv
// Shared constants and encodings for the video frame-stream source.
package video_stream_pkg;

    localparam int DEF_H_ACTIVE = 702;
    localparam int DEF_V_ACTIVE = 288;
    localparam int DEF_H_BLANK  = 16;
    localparam int DEF_V_FRONT  = 4;
    localparam int DEF_V_BLANK  = 64;
    localparam int DEF_ADDR_W   = 20;

    // Width of the h/v/blank counters; wide enough for any practical timing.
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FRONT  = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_HBLANK = 3'd3,
        ST_VBLANK = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PAT_MEM   = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_t;

endpackage

// File: rtl/video_stream_source_pattern_gen.sv
// Registered test-pattern pixel; zero outside active pixels and in memory mode.
module video_pattern_gen
    import video_stream_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    input  pattern_t   pattern_i,
    input  logic [7:0] h_i,
    input  logic       v5_i,
    output logic [7:0] pix_o
);

    logic [7:0] pix_q;
    logic [7:0] pix_d;

    always_comb begin
        pix_d = 8'd0;
        if (valid_i) begin
            case (pattern_i)
                PAT_RAMP:  pix_d = h_i;
                PAT_CHECK: pix_d = (h_i[5] ^ v5_i) ? 8'd255 : 8'd0;
                PAT_SOLID: pix_d = 8'd128;
                default:   pix_d = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_q <= 8'd0;
        end else begin
            pix_q <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/video_stream_source.sv
// Frame-stream transmitter: FSM and counters produce frame/line/pixel timing,
// and every video output is registered one cycle behind the internal state.
module video_stream_source
    import video_stream_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int H_BLANK  = DEF_H_BLANK,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_BLANK  = DEF_V_BLANK,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              video_frame_valid,
    output logic              video_line_valid,
    output logic              video_data_valid,
    output logic [7:0]        video_data_out,
    output logic [ADDR_W-1:0] video_address,
    output logic [9:0]        frame_count,
    output logic              frame_done,
    output logic [2:0]        debug_state
);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] FRONT_LAST = CNT_W'(V_FRONT - 1);
    localparam logic [CNT_W-1:0] VB_LAST    = CNT_W'(V_BLANK - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t              state_q, state_d;
    pattern_t            pat_q, pat_d;
    logic [CNT_W-1:0]    h_q, h_d;
    logic [CNT_W-1:0]    v_q, v_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                start_frame;

    logic                mem_rd_en_q;
    logic [ADDR_W-1:0]   mem_rd_addr_q;
    logic                frame_valid_q;
    logic                data_valid_q;
    logic                mem_sel_q;
    logic [ADDR_W-1:0]   video_address_q;
    logic [9:0]          frame_count_q;
    logic                frame_done_q;
    logic [7:0]          pat_pix;
    logic                frame_end;

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        h_d         = h_q;
        v_d         = v_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        start_frame = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start_frame = enable;
            end
            ST_FRONT: begin
                if (cnt_q == FRONT_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ACTIVE: begin
                // Running address replaces v*H_ACTIVE+h; it continues across lines.
                addr_d = addr_q + ADDR_ONE;
                if (h_q == H_LAST) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    h_d = h_q + CNT_ONE;
                end
            end
            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    cnt_d = '0;
                    h_d   = '0;
                    if (v_q == V_LAST) begin
                        state_d = ST_VBLANK;
                    end else begin
                        state_d = ST_ACTIVE;
                        v_d     = v_q + CNT_ONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d       = '0;
                    start_frame = enable;
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (start_frame) begin
            state_d = ST_FRONT;
            pat_d   = pattern_t'(pattern_sel);
            h_d     = '0;
            v_d     = '0;
            cnt_d   = '0;
            addr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_MEM;
            h_q     <= '0;
            v_q     <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            h_q     <= h_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    // First VBLANK cycle: the registered frame_valid drops on the same edge.
    assign frame_end = (state_q == ST_VBLANK) && (cnt_q == '0);

    // Read strobe is built from next-state so the returned data lands with data_valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_rd_en_q     <= 1'b0;
            mem_rd_addr_q   <= '0;
            frame_valid_q   <= 1'b0;
            data_valid_q    <= 1'b0;
            mem_sel_q       <= 1'b0;
            video_address_q <= '0;
            frame_count_q   <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            mem_rd_en_q <= (state_d == ST_ACTIVE) && (pat_d == PAT_MEM);
            if ((state_d == ST_ACTIVE) && (pat_d == PAT_MEM)) begin
                mem_rd_addr_q <= addr_d;
            end
            frame_valid_q <= state_q inside {ST_FRONT, ST_ACTIVE, ST_HBLANK};
            data_valid_q  <= (state_q == ST_ACTIVE);
            mem_sel_q     <= (state_q == ST_ACTIVE) && (pat_q == PAT_MEM);
            if (state_q == ST_ACTIVE) begin
                video_address_q <= addr_q;
            end
            frame_done_q <= frame_end;
            if (frame_end) begin
                frame_count_q <= frame_count_q + 10'd1;
            end
        end
    end

    video_pattern_gen u_pattern_gen (
        .clk       (clk),
        .reset     (reset),
        .valid_i   ((state_q == ST_ACTIVE) && (pat_q != PAT_MEM)),
        .pattern_i (pat_q),
        .h_i       (h_q[7:0]),
        .v5_i      (v_q[5]),
        .pix_o     (pat_pix)
    );

    assign mem_rd_en         = mem_rd_en_q;
    assign mem_rd_addr       = mem_rd_addr_q;
    assign video_frame_valid = frame_valid_q;
    assign video_line_valid  = data_valid_q;
    assign video_data_valid  = data_valid_q;
    assign video_data_out    = mem_sel_q ? mem_rd_data : pat_pix;
    assign video_address     = video_address_q;
    assign frame_count       = frame_count_q;
    assign frame_done        = frame_done_q;
    assign debug_state       = state_q;

endmodule

// File: tb/tb_video_stream_source.sv
// Scoreboard bench for video_stream_source with a small 8x4 frame geometry.
module tb_video_stream_source;

    localparam int H_ACT  = 8;
    localparam int V_ACT  = 4;
    localparam int H_BLK  = 2;
    localparam int V_FRT  = 3;
    localparam int V_BLK  = 5;
    localparam int AW     = 20;
    localparam int FV_LEN = V_FRT + V_ACT * (H_ACT + H_BLK);
    localparam logic [2:0] IDLE_CODE = 3'd0;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [1:0]    pattern_sel;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [7:0]    mem_rd_data;
    logic          video_frame_valid;
    logic          video_line_valid;
    logic          video_data_valid;
    logic [7:0]    video_data_out;
    logic [AW-1:0] video_address;
    logic [9:0]    frame_count;
    logic          frame_done;
    logic [2:0]    debug_state;

    int tests_run = 0;
    int fails = 0;
    logic [AW+7:0] exp_q[$];

    // monitor-owned statistics
    int done_cnt = 0, rd_cnt = 0, mem_en_cnt = 0, fv_rise = 0, lv_fall = 0;
    int fv_run = 0, low_run = 0, min_fv = 0, max_fv = 0, min_gap = 0, max_gap = 0;
    bit seen_fall = 0, prev_fv = 0, prev_lv = 0;
    int clr_gen = 0, clr_seen = 0;

    video_stream_source #(
        .H_ACTIVE (H_ACT),
        .V_ACTIVE (V_ACT),
        .H_BLANK  (H_BLK),
        .V_FRONT  (V_FRT),
        .V_BLANK  (V_BLK),
        .ADDR_W   (AW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .pattern_sel       (pattern_sel),
        .mem_rd_en         (mem_rd_en),
        .mem_rd_addr       (mem_rd_addr),
        .mem_rd_data       (mem_rd_data),
        .video_frame_valid (video_frame_valid),
        .video_line_valid  (video_line_valid),
        .video_data_valid  (video_data_valid),
        .video_data_out    (video_data_out),
        .video_address     (video_address),
        .frame_count       (frame_count),
        .frame_done        (frame_done),
        .debug_state       (debug_state)
    );

    // clock / memory model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? mem_rd_addr[7:0] : 8'($urandom_range(0, 255));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_frame(input int pat);
        logic [AW-1:0] a;
        logic [7:0]    p;
        for (int v = 0; v < V_ACT; v++) begin
            for (int h = 0; h < H_ACT; h++) begin
                a = AW'(v * H_ACT + h);
                case (pat)
                    0:       p = a[7:0];
                    1:       p = 8'(h);
                    2:       p = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? 8'd255 : 8'd0;
                    default: p = 8'd128;
                endcase
                exp_q.push_back({a, p});
            end
        end
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int start;
        int c;
        start = done_cnt;
        c = 0;
        while ((done_cnt - start) < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, done_cnt - start, n);
    endtask

    task automatic wait_lv_fall(input int n, input int budget, input string tag);
        int c;
        c = 0;
        while (lv_fall < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, lv_fall, n);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        clr_gen++;
        idle_cycles(1);
    endtask

    // monitor: pixel scoreboard plus frame/line timing statistics
    always @(negedge clk) begin
        logic [AW+7:0] e;
        if (clr_seen != clr_gen) begin
            clr_seen  = clr_gen;
            lv_fall   = 0;
            min_fv    = 32'h7fffffff;
            max_fv    = 0;
            min_gap   = 32'h7fffffff;
            max_gap   = 0;
            seen_fall = 0;
        end
        check("lv_eq_dv", video_line_valid, video_data_valid);
        if (video_data_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pixel", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("pix_data", video_data_out, e[7:0]);
                check("pix_addr", video_address, e[AW+7:8]);
            end
        end else begin
            check("dout_idle", video_data_out, 0);
        end
        if (mem_rd_en) begin
            check("rd_addr", mem_rd_addr, rd_cnt % (H_ACT * V_ACT));
            rd_cnt++;
            mem_en_cnt++;
        end
        if (prev_lv && !video_line_valid) lv_fall++;
        if (video_frame_valid) begin
            if (!prev_fv) begin
                fv_rise++;
                if (seen_fall) begin
                    if (low_run < min_gap) min_gap = low_run;
                    if (low_run > max_gap) max_gap = low_run;
                end
                fv_run = 0;
            end
            fv_run++;
        end else begin
            if (prev_fv) begin
                if (fv_run < min_fv) min_fv = fv_run;
                if (fv_run > max_fv) max_fv = fv_run;
                seen_fall = 1;
                low_run   = 0;
            end
            low_run++;
        end
        if (frame_done) begin
            done_cnt++;
            check("done_align", {30'd0, prev_fv, video_frame_valid}, 2);
        end
        prev_fv = video_frame_valid;
        prev_lv = video_line_valid;
    end

    initial begin
        int base;
        reset       = 1'b1;
        enable      = 1'b0;
        pattern_sel = 2'd0;
        idle_cycles(3);
        check("rst_fv", video_frame_valid, 0);
        check("rst_lv", video_line_valid, 0);
        check("rst_dv", video_data_valid, 0);
        check("rst_dout", video_data_out, 0);
        check("rst_addr", video_address, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_rd_addr", mem_rd_addr, 0);
        check("rst_count", frame_count, 0);
        check("rst_done", frame_done, 0);
        check("rst_state", debug_state, IDLE_CODE);
        reset = 1'b0;
        clear_stats();

        // memory mode, single frame
        push_frame(0);
        base = rd_cnt;
        enable = 1'b1;
        wait_done(1, 200, "t1_done");
        enable = 1'b0;
        check("t1_lines", lv_fall, V_ACT);
        check("t1_fv_min", min_fv, FV_LEN);
        check("t1_fv_max", max_fv, FV_LEN);
        check("t1_reads", rd_cnt - base, H_ACT * V_ACT);
        check("t1_count", frame_count, 1);
        idle_cycles(12);
        check("t1_idle", debug_state, IDLE_CODE);
        check("t1_q_empty", exp_q.size(), 0);

        // horizontal ramp, no memory traffic
        clear_stats();
        base = mem_en_cnt;
        pattern_sel = 2'd1;
        push_frame(1);
        enable = 1'b1;
        wait_done(1, 200, "t2_done");
        enable = 1'b0;
        check("t2_no_reads", mem_en_cnt - base, 0);
        check("t2_lines", lv_fall, V_ACT);
        check("t2_count", frame_count, 2);
        idle_cycles(12);
        check("t2_q_empty", exp_q.size(), 0);

        // enable dropped during line 1
        clear_stats();
        pattern_sel = 2'd0;
        push_frame(0);
        enable = 1'b1;
        wait_lv_fall(1, 100, "t3_line0");
        idle_cycles(3);
        enable = 1'b0;
        wait_done(1, 200, "t3_done");
        check("t3_lines", lv_fall, V_ACT);
        check("t3_count", frame_count, 3);
        base = fv_rise;
        idle_cycles(25);
        check("t3_no_restart", fv_rise - base, 0);
        check("t3_fv_low", video_frame_valid, 0);
        check("t3_idle", debug_state, IDLE_CODE);
        check("t3_q_empty", exp_q.size(), 0);

        // reset mid-line 2, then a fresh frame
        clear_stats();
        pattern_sel = 2'd1;
        push_frame(1);
        enable = 1'b1;
        wait_lv_fall(2, 100, "t4_line1");
        idle_cycles(3);
        check("t4_midline", video_line_valid, 1);
        base = done_cnt;
        reset = 1'b1;
        enable = 1'b0;
        idle_cycles(1);
        check("t4_fv", video_frame_valid, 0);
        check("t4_lv", video_line_valid, 0);
        check("t4_dv", video_data_valid, 0);
        check("t4_dout", video_data_out, 0);
        check("t4_addr", video_address, 0);
        check("t4_count", frame_count, 0);
        check("t4_rd_en", mem_rd_en, 0);
        exp_q.delete();
        idle_cycles(2);
        reset = 1'b0;
        check("t4_no_done", done_cnt - base, 0);
        pattern_sel = 2'd0;
        push_frame(0);
        enable = 1'b1;
        idle_cycles(3);
        check("t4_new_fv", video_frame_valid, 1);
        check("t4_new_count", frame_count, 0);
        wait_done(1, 200, "t4_done");
        enable = 1'b0;
        check("t4_count_after", frame_count, 1);
        idle_cycles(12);
        check("t4_q_empty", exp_q.size(), 0);

        // pattern change mid-frame applies to the next frame only
        clear_stats();
        base = mem_en_cnt;
        pattern_sel = 2'd1;
        push_frame(1);
        push_frame(2);
        enable = 1'b1;
        wait_lv_fall(1, 100, "t5_line0");
        pattern_sel = 2'd2;
        wait_done(1, 200, "t5_done1");
        wait_done(1, 200, "t5_done2");
        enable = 1'b0;
        check("t5_lines", lv_fall, 2 * V_ACT);
        check("t5_no_reads", mem_en_cnt - base, 0);
        check("t5_count", frame_count, 3);
        idle_cycles(12);
        check("t5_q_empty", exp_q.size(), 0);

        // 1024 back-to-back frames: counter wrap and inter-frame gap
        reset = 1'b1;
        idle_cycles(2);
        reset = 1'b0;
        exp_q.delete();
        clear_stats();
        pattern_sel = 2'd3;
        for (int f = 0; f < 1024; f++) push_frame(3);
        enable = 1'b1;
        wait_done(1023, 60000, "t6_done1023");
        check("t6_count1023", frame_count, 1023);
        wait_done(1, 200, "t6_done1024");
        enable = 1'b0;
        check("t6_wrap", frame_count, 0);
        check("t6_gap_min", min_gap, V_BLK);
        check("t6_gap_max", max_gap, V_BLK);
        check("t6_fv_min", min_fv, FV_LEN);
        check("t6_fv_max", max_fv, FV_LEN);
        check("t6_lines", lv_fall, 1024 * V_ACT);
        idle_cycles(12);
        check("t6_idle", debug_state, IDLE_CODE);
        check("t6_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
